musb_gpr_bank: RTL and testbench
================================

Name: musb_gpr_bank

Overview:
- Parametrised general-purpose register bank for the MUSB core and derived cores.
- Two combinational read ports and one synchronous write port; storage has no per-bit reset so it maps to BRAM or distributed RAM.
- Optional hardware clear sequencer sweeps all entries to zero after reset.
- Optional same-cycle write-to-read bypass.
- Sits between the decode stage (reads) and the writeback stage (write).

Parameters:
DATA_WIDTH, 32, width of each register in bits
ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH entries
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes to it discarded); 0 = entry 0 is an ordinary register
BYPASS, 1, 1 = a read of the address being written this cycle returns gpr_wd; 0 = read returns the stored (old) value
CLEAR_ON_RESET, 1, 1 = clear sequencer zeroes all writable entries after reset; 0 = no sweep, contents undefined after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
gpr_ra_a  input  ADDR_WIDTH  read address, port A
gpr_ra_b  input  ADDR_WIDTH  read address, port B
gpr_wa  input  ADDR_WIDTH  write address
gpr_wd  input  DATA_WIDTH  write data
gpr_we  input  1  write enable
gpr_rd_a  output  DATA_WIDTH  read data, port A (combinational)
gpr_rd_b  output  DATA_WIDTH  read data, port B (combinational)
gpr_busy  output  1  high while reset is asserted or the clear sweep is in progress; writes are dropped and reads return 0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array with no reset term. With ZERO_REG=1, entry 0 is not stored.
- First writable address F = ZERO_REG ? 1 : 0. Last address L = 2**ADDR_WIDTH-1.
- FSM states, CLEAR_ON_RESET=1:
  - rst=1: state <= CLEAR, clr_cnt <= F, gpr_busy=1.
  - CLEAR, rst=0: each cycle write 0 to entry clr_cnt and increment clr_cnt. When clr_cnt==L, state <= IDLE at that edge.
  - IDLE: normal operation; stays in IDLE until rst.
- Clear duration: gpr_busy stays high for exactly L-F+1 cycles after rst falls. Defaults: 31 cycles.
- rst during CLEAR: sweep restarts from F on the next cycle with rst low.
- CLEAR_ON_RESET=0: rst forces state IDLE and gpr_busy=0 in the same cycle. Contents are untouched (X in simulation until written).
- Read outputs during CLEAR (including while rst=1): gpr_rd_a and gpr_rd_b are 0.
- Write (IDLE only): on the rising edge, if gpr_we=1 and not (ZERO_REG && gpr_wa==0), entry[gpr_wa] <= gpr_wd. Otherwise the entry holds its value.
- Writes presented while busy are discarded silently. The producer must hold off on gpr_busy.
- Read port A (IDLE), in priority order; port B is identical with gpr_ra_b:
  1. ZERO_REG && gpr_ra_a==0 -> 0.
  2. BYPASS && gpr_we && gpr_wa==gpr_ra_a (and the write is not to a discarded entry 0) -> gpr_wd.
  3. Otherwise -> entry[gpr_ra_a].
- Latency: read is zero-cycle (combinational). A write becomes visible on the next cycle, or in the same cycle with BYPASS=1.
- Both read ports may address the same entry, or the write address, at the same time. Each resolves independently with the same rules.
- No arithmetic other than the clr_cnt increment. clr_cnt is ADDR_WIDTH bits and never wraps, because the FSM exits at L.

Test Plan:
- Defaults; rst high 3 cycles, then low -> gpr_busy=1 for exactly 31 cycles after rst falls, then 0. Reading every address 0..31 then returns 0x00000000.
- Defaults, IDLE; write wa=5, wd=0xDEADBEEF, we=1 with ra_a=5, ra_b=5 in the same cycle -> both ports show 0xDEADBEEF in that cycle (bypass). Next cycle with we=0 -> still 0xDEADBEEF.
- BYPASS=0; same write -> ra_a=5 shows the old value (0) in the write cycle and 0xDEADBEEF in the next cycle.
- ZERO_REG=1; write wa=0, wd=0x12345678, ra_a=0 -> rd_a=0 in that cycle and every later cycle. ZERO_REG=0 with the same stimulus -> rd_a=0x12345678 in that cycle (bypass) and the next.
- Re-assert rst for 1 cycle at sweep cycle 10 -> busy stays high and the sweep restarts; busy falls 31 cycles after the second rst falls. A write of 0xA5A5A5A5 to wa=7 during busy is dropped and reads 0 after the sweep.
- ADDR_WIDTH=3, DATA_WIDTH=16, ZERO_REG=0 -> busy lasts 8 cycles after rst. Fill entries 0..7 with 0x1000+i, then read all pairs (a,b) -> rd_a=0x1000+a and rd_b=0x1000+b.

Source files
------------

// File: rtl/musb_gpr_bank.sv
// MUSB general-purpose register bank: two combinational read ports, one write port,
// optional post-reset clear sweep, hardwired zero entry and write-to-read bypass.
module musb_gpr_bank #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned ZERO_REG       = 1,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] gpr_ra_a,
  input  logic [ADDR_WIDTH-1:0] gpr_ra_b,
  input  logic [ADDR_WIDTH-1:0] gpr_wa,
  input  logic [DATA_WIDTH-1:0] gpr_wd,
  input  logic                  gpr_we,
  output logic [DATA_WIDTH-1:0] gpr_rd_a,
  output logic [DATA_WIDTH-1:0] gpr_rd_b,
  output logic                  gpr_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'((ZERO_REG != 0) ? 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we_c;
  logic                  wr_en_c;

  // Storage deliberately has no reset so it can map onto RAM primitives.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= FIRST;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Sweep one entry per cycle; leave at the last address so the counter never wraps.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_c  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_c = ~rst;
        if (clr_cnt_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign gpr_busy = (CLEAR_ON_RESET != 0) && (rst || (state_q == ST_CLEAR));
  assign wr_en_c  = gpr_we && !gpr_busy && !((ZERO_REG != 0) && (gpr_wa == '0));

  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en_c) begin
      mem_q[gpr_wa] <= gpr_wd;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] ra,
    input logic                  busy,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wa,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] rd;
    rd = stored;
    if (busy) begin
      rd = '0;
    end else if ((ZERO_REG != 0) && (ra == '0)) begin
      rd = '0;
    end else if ((BYPASS != 0) && wr_en && (wa == ra)) begin
      rd = wd;
    end
    return rd;
  endfunction

  assign gpr_rd_a = read_port(gpr_ra_a, gpr_busy, wr_en_c, gpr_wa, gpr_wd, mem_q[gpr_ra_a]);
  assign gpr_rd_b = read_port(gpr_ra_b, gpr_busy, wr_en_c, gpr_wa, gpr_wd, mem_q[gpr_ra_b]);

endmodule

// File: tb/tb_musb_gpr_bank.sv
// Bench for musb_gpr_bank: five parameter variants on one shared stimulus stream,
// checked every cycle against an array-based model plus directed vectors.
module tb_musb_gpr_bank;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  ra_a, ra_b, wa;
  logic [31:0] wd;

  logic [31:0] def_a, def_b, nb_a, nb_b, nz_a, nz_b, nc_a, nc_b;
  logic [15:0] sm_a, sm_b;
  logic        def_busy, nb_busy, nz_busy, nc_busy, sm_busy;

  musb_gpr_bank u_def (
    .clk(clk), .rst(rst), .gpr_ra_a(ra_a), .gpr_ra_b(ra_b), .gpr_wa(wa), .gpr_wd(wd),
    .gpr_we(we), .gpr_rd_a(def_a), .gpr_rd_b(def_b), .gpr_busy(def_busy));

  musb_gpr_bank #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .gpr_ra_a(ra_a), .gpr_ra_b(ra_b), .gpr_wa(wa), .gpr_wd(wd),
    .gpr_we(we), .gpr_rd_a(nb_a), .gpr_rd_b(nb_b), .gpr_busy(nb_busy));

  musb_gpr_bank #(.ZERO_REG(0)) u_nz (
    .clk(clk), .rst(rst), .gpr_ra_a(ra_a), .gpr_ra_b(ra_b), .gpr_wa(wa), .gpr_wd(wd),
    .gpr_we(we), .gpr_rd_a(nz_a), .gpr_rd_b(nz_b), .gpr_busy(nz_busy));

  musb_gpr_bank #(.CLEAR_ON_RESET(0)) u_nc (
    .clk(clk), .rst(rst), .gpr_ra_a(ra_a), .gpr_ra_b(ra_b), .gpr_wa(wa), .gpr_wd(wd),
    .gpr_we(we), .gpr_rd_a(nc_a), .gpr_rd_b(nc_b), .gpr_busy(nc_busy));

  musb_gpr_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) u_sm (
    .clk(clk), .rst(rst), .gpr_ra_a(ra_a[2:0]), .gpr_ra_b(ra_b[2:0]), .gpr_wa(wa[2:0]),
    .gpr_wd(wd[15:0]), .gpr_we(we), .gpr_rd_a(sm_a), .gpr_rd_b(sm_b), .gpr_busy(sm_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the four clearing variants: 0=default, 1=no bypass, 2=no zero reg, 3=small.
  localparam int NI = 4;
  int          zr_p   [NI] = '{1, 1, 0, 0};
  int          byp_p  [NI] = '{1, 0, 1, 1};
  int          sweep_p[NI] = '{31, 31, 32, 8};
  logic [4:0]  am_p   [NI] = '{5'd31, 5'd31, 5'd31, 5'd7};
  logic [31:0] dm_p   [NI] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] mdl    [NI][32];
  int          rem    [NI];

  logic [31:0] act_a [NI];
  logic [31:0] act_b [NI];
  logic        act_busy [NI];
  logic [31:0] smp_a [NI];
  logic [31:0] smp_b [NI];
  logic        smp_busy [NI];

  assign act_a[0] = def_a;  assign act_b[0] = def_b;  assign act_busy[0] = def_busy;
  assign act_a[1] = nb_a;   assign act_b[1] = nb_b;   assign act_busy[1] = nb_busy;
  assign act_a[2] = nz_a;   assign act_b[2] = nz_b;   assign act_busy[2] = nz_busy;
  assign act_a[3] = {16'h0, sm_a}; assign act_b[3] = {16'h0, sm_b}; assign act_busy[3] = sm_busy;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic exp_busy(input int k);
    return rst || (rem[k] > 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] ra);
    logic [4:0] a;
    logic [4:0] w;
    a = ra & am_p[k];
    w = wa & am_p[k];
    if (exp_busy(k)) return 32'h0;
    if (zr_p[k] != 0 && a == 5'd0) return 32'h0;
    if (byp_p[k] != 0 && we && w == a && !(zr_p[k] != 0 && w == 5'd0)) return wd & dm_p[k];
    return mdl[k][a];
  endfunction

  // Sample and check all variants mid-cycle, then advance the model at the edge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      smp_a[k]    = act_a[k];
      smp_b[k]    = act_b[k];
      smp_busy[k] = act_busy[k];
      check("busy", k, {31'h0, act_busy[k]}, {31'h0, exp_busy(k)});
      check("rd_a", k, act_a[k], exp_rd(k, ra_a));
      check("rd_b", k, act_b[k], exp_rd(k, ra_b));
    end
    check("nc_busy", 4, {31'h0, nc_busy}, 32'h0);
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        rem[k] = sweep_p[k];
        for (int i = 0; i < 32; i++) mdl[k][i] = 32'h0;
      end else if (rem[k] > 0) begin
        rem[k]--;
      end else if (we && !(zr_p[k] != 0 && wa == 5'd0)) begin
        mdl[k][wa & am_p[k]] = wd & dm_p[k];
      end
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] a_w,
                       input logic [31:0] d, input logic [4:0] a_a, input logic [4:0] a_b);
    rst = r; we = w; wa = a_w; wd = d; ra_a = a_a; ra_b = a_b;
  endtask

  // Count busy cycles of variants 0 and 3 over a fixed window after reset falls.
  task automatic measure_busy(input int exp_def, input int exp_sm, input logic first_we);
    int c_def;
    int c_sm;
    c_def = 0;
    c_sm  = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 && first_we) drive(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
      else                    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      cycle();
      if (smp_busy[0]) c_def++;
      if (smp_busy[3]) c_sm++;
    end
    check("busy_len_def", 0, 32'(c_def), 32'(exp_def));
    check("busy_len_sm", 3, 32'(c_sm), 32'(exp_sm));
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra_a;
    logic [4:0]  ra_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
    tbl[4] = '{1'b1, 5'd9,  32'hCAFE_F00D, 5'd9,  5'd3,  32'hCAFE_F00D, 32'h0};
    tbl[5] = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd9,  32'h0,         32'hCAFE_F00D};
    tbl[6] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'h0};
    tbl[7] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd0,  32'hFFFF_FFFF, 32'h0};
    for (int k = 0; k < NI; k++) rem[k] = 0;

    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) cycle();
    measure_busy(31, 8, 1'b0);

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      cycle();
    end

    for (int v = 0; v < 8; v++) begin
      drive(1'b0, tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].ra_a, tbl[v].ra_b);
      cycle();
      check("tbl_busy", v, {31'h0, smp_busy[0]}, 32'h0);
      check("tbl_rd_a", v, smp_a[0], tbl[v].exp_a);
      check("tbl_rd_b", v, smp_b[0], tbl[v].exp_b);
    end

    // Reset pulse at sweep cycle 10 restarts the sweep; a write while busy is dropped.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'd7);
      cycle();
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle();
    measure_busy(31, 8, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    cycle();
    check("dropped_wr", 0, smp_a[0], 32'h0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'h1000 + 32'(i), 5'd0, 5'd0);
      cycle();
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(b));
        cycle();
        check("sm_pair_a", 3, smp_a[3], 32'h1000 + 32'(a));
        check("sm_pair_b", 3, smp_b[3], 32'h1000 + 32'(b));
      end
    end

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0), 1'($urandom), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) ra_a = wa;
      if ($urandom_range(0, 3) == 0) ra_b = wa;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
